// File: rtl/l2_port_scheduler.sv
// l2_port_scheduler: arbitrates the shared L2 port between two cores and runs each L2 transaction.
// Ports: reset (async, active-high); req/op/addr and flush/wb_data/wb_tag per core in;
// grant and done per core out; resp_data/resp_hit/resp_err with done;
// l2_req/l2_we/l2_addr/l2_wdata/l2_tag to L2; l2_ack/l2_rdata/l2_hit from L2;
// timeout_err is sticky.
module l2_port_scheduler #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_core1,
  input  logic              req_core2,
  input  logic [1:0]        op_core1,
  input  logic [1:0]        op_core2,
  input  logic [ADDR_W-1:0] addr_core1,
  input  logic [ADDR_W-1:0] addr_core2,
  input  logic              flush_core1,
  input  logic              flush_core2,
  input  logic [DATA_W-1:0] wb_data_core1,
  input  logic [DATA_W-1:0] wb_data_core2,
  input  logic [TAG_W-1:0]  wb_tag_core1,
  input  logic [TAG_W-1:0]  wb_tag_core2,
  output logic              grant_core1,
  output logic              grant_core2,
  output logic              done_core1,
  output logic              done_core2,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              resp_err,
  output logic              l2_req,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  output logic [TAG_W-1:0]  l2_tag,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic [1:0]        l2_hit,
  output logic              timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_n;
  logic sel, ptr, lat_flush;
  logic [CW-1:0] cnt;
  logic p1, p2, win2, upg_win, timeout, start, hit;
  assign p1 = flush_core1 | (req_core1 & op_core1 != 2'b11);
  assign p2 = flush_core2 | (req_core2 & op_core2 != 2'b11);
  // Flush outranks a plain request; within the same class the RR pointer decides.
  assign win2 = p2 & (~p1 | (flush_core2 & ~flush_core1) | ((flush_core2 == flush_core1) & ptr));
  // A BusUpgr winner needs no L2 access; a pending flush is always served first.
  assign upg_win = win2 ? (~flush_core2 & op_core2 == 2'b01) : (~flush_core1 & op_core1 == 2'b01);
  assign start = state == IDLE && (p1 | p2);
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign hit = ~lat_flush & l2_hit == 2'b10;
  always_comb begin
    state_n = state == IDLE ? ((p1 | p2) ? (upg_win ? RESP : ISSUE) : IDLE)
            : state == ISSUE ? ((l2_ack | timeout) ? RESP : ISSUE)
            : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel <= 1'b0;
      ptr <= 1'b0;
      lat_flush <= 1'b0;
      l2_addr <= '0;
      l2_wdata <= '0;
      l2_tag <= '0;
      cnt <= '0;
      resp_data <= '0;
      resp_hit <= 1'b0;
      resp_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (start) begin
        sel <= win2;
        lat_flush <= win2 ? flush_core2 : flush_core1;
        l2_addr <= win2 ? addr_core2 : addr_core1;
        l2_wdata <= win2 ? wb_data_core2 : wb_data_core1;
        l2_tag <= win2 ? wb_tag_core2 : wb_tag_core1;
        cnt <= '0;
        if (upg_win) begin
          resp_data <= '0;
          resp_hit <= 1'b0;
          resp_err <= 1'b0;
        end
      end
      if (state == ISSUE) begin
        cnt <= cnt + 1'b1;
        if (l2_ack) begin
          resp_data <= hit ? l2_rdata : '0;
          resp_hit <= hit;
          resp_err <= 1'b0;
        end else if (timeout) begin
          resp_data <= '0;
          resp_hit <= 1'b0;
          resp_err <= 1'b1;
          timeout_err <= 1'b1;
        end
      end
      if (state == RESP) ptr <= ~sel;
    end
  end
  assign grant_core1 = state != IDLE && !sel;
  assign grant_core2 = state != IDLE && sel;
  assign done_core1 = state == RESP && !sel;
  assign done_core2 = state == RESP && sel;
  assign l2_req = state == ISSUE;
  assign l2_we = l2_req & lat_flush;
endmodule
